// File: rtl/pc_seq_if.sv
// pc_seq_if: control-unit / stack-side bundle for the program-counter sequencer.
//
// Signals (direction as seen by the sequencer, i.e. the slave modport):
//   en            in   start request from the control unit
//   control_bus   in   4-bit instruction class
//   z_flag        in   ALU zero flag (used by JZ)
//   s_flag        in   ALU sign flag (used by JS)
//   stk_data_out  in   target word from the external data stack
//   stk_pop       out  one-cycle pop strobe to the external stack
//   pc            out  program counter
//   fin_sig       out  one-cycle completion pulse
//   busy          out  instruction in flight
//   halted        out  EXIT has been executed
//   fault         out  sticky error flag
interface pc_seq_if #(
    parameter int DATA_LEN = 8,
    parameter int PC_W     = 6
);
    logic                en;
    logic [3:0]          control_bus;
    logic                z_flag;
    logic                s_flag;
    logic [DATA_LEN-1:0] stk_data_out;
    logic                stk_pop;
    logic [PC_W-1:0]     pc;
    logic                fin_sig;
    logic                busy;
    logic                halted;
    logic                fault;

    // Control unit / testbench side
    modport master (
        output en, control_bus, z_flag, s_flag, stk_data_out,
        input  stk_pop, pc, fin_sig, busy, halted, fault
    );

    // Sequencer side
    modport slave (
        input  en, control_bus, z_flag, s_flag, stk_data_out,
        output stk_pop, pc, fin_sig, busy, halted, fault
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer.
//
// Walks the PC per instruction class presented on control_bus, fetches
// branch/call targets from the external data stack with a one-cycle pop
// strobe, keeps an internal return-address stack for CALL/RET, range-checks
// every jump target and raises a sticky fault flag on any error.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rstn  asynchronous active-low reset
//   ctl   pc_seq_if.slave bundle (en, control_bus, flags, stack data in;
//         stk_pop, pc, fin_sig, busy, halted, fault out; all outputs registered)
module pc_seq #(
    parameter int  INST_CAP  = 20,
    parameter int  DATA_LEN  = 8,
    parameter int  RET_DEPTH = 4,
    localparam int PC_W      = $clog2(INST_CAP) + 1
) (
    input  logic     clk,
    input  logic     rstn,
    pc_seq_if.slave  ctl
);

    localparam int SPW  = $clog2(RET_DEPTH + 1);
    localparam int IDXW = (RET_DEPTH > 1) ? $clog2(RET_DEPTH) : 1;
    localparam int TW   = (DATA_LEN > PC_W) ? DATA_LEN : PC_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADV  = 3'd1,
        S_POP  = 3'd2,
        S_BR   = 3'd3,
        S_RET  = 3'd4,
        S_HALT = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OP_ADV  = 3'd0,
        OP_JMP  = 3'd1,
        OP_JZ   = 3'd2,
        OP_JS   = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_EXIT = 3'd6
    } op_e;

    // STALL codes (1000-1110) fall through to ADV together with 0000-0010.
    function automatic op_e decode(input logic [3:0] cb);
        op_e op;
        case (cb)
            4'b0011: op = OP_JMP;
            4'b0100: op = OP_JZ;
            4'b0101: op = OP_JS;
            4'b0110: op = OP_CALL;
            4'b0111: op = OP_RET;
            4'b1111: op = OP_EXIT;
            default: op = OP_ADV;
        endcase
        return op;
    endfunction

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              stk_pop_q, stk_pop_d;
    logic              fin_q, fin_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              fault_q, fault_d;

    logic [PC_W-1:0]   ret_q [RET_DEPTH];
    logic [SPW-1:0]    sp_q;

    logic              push_s;
    logic              pop_s;
    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   tgt_s;
    logic [TW-1:0]     tgt_ext_s;
    logic              unused_tgt_s;
    logic              tgt_oor_s;
    logic              taken_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic [IDXW-1:0]   wr_idx_s;
    logic [IDXW-1:0]   top_idx_s;
    logic [PC_W-1:0]   top_s;

    // Saturating increment, target resize/range check and return-stack taps.
    always_comb begin
        pc_inc_s     = (pc_q >= PC_W'(INST_CAP - 1)) ? pc_q : (pc_q + PC_W'(1));
        tgt_ext_s    = TW'(ctl.stk_data_out);
        tgt_s        = tgt_ext_s[PC_W-1:0];
        unused_tgt_s = ^tgt_ext_s;
        tgt_oor_s    = (tgt_s >= PC_W'(INST_CAP));
        stk_full_s   = (sp_q == SPW'(RET_DEPTH));
        stk_empty_s  = (sp_q == {SPW{1'b0}});
        wr_idx_s     = IDXW'(sp_q);
        top_idx_s    = IDXW'(sp_q - SPW'(1));
        top_s        = ret_q[top_idx_s];
    end

    // Branch take decision; flags are only consumed in BR.
    always_comb begin
        taken_s = 1'b0;
        case (op_q)
            OP_JMP, OP_CALL: taken_s = 1'b1;
            OP_JZ:           taken_s = ctl.z_flag;
            OP_JS:           taken_s = ctl.s_flag;
            default:         taken_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pc_d      = pc_q;
        stk_pop_d = 1'b0;
        fin_d     = 1'b0;
        halted_d  = halted_q;
        fault_d   = fault_q;
        push_s    = 1'b0;
        pop_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl.en) begin
                    op_d = decode(ctl.control_bus);
                    case (op_d)
                        OP_JMP, OP_JZ, OP_JS, OP_CALL: begin
                            state_d   = S_POP;
                            stk_pop_d = 1'b1;
                        end
                        OP_RET:  state_d = S_RET;
                        OP_EXIT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                        default: state_d = S_ADV;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADV: begin
                pc_d    = pc_inc_s;
                fin_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_POP: begin
                // Target word is sampled at the following (BR) edge.
                state_d = S_BR;
            end
            S_BR: begin
                if (taken_s && tgt_oor_s) begin
                    fault_d = 1'b1;
                    pc_d    = pc_inc_s;
                end else if (taken_s && (op_q == OP_CALL) && stk_full_s) begin
                    fault_d = 1'b1;
                    pc_d    = pc_inc_s;
                end else if (taken_s && (op_q == OP_CALL)) begin
                    push_s  = 1'b1;
                    pc_d    = tgt_s;
                end else if (taken_s) begin
                    pc_d    = tgt_s;
                end else begin
                    pc_d    = pc_inc_s;
                end
                fin_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_RET: begin
                if (!stk_empty_s) begin
                    pc_d  = top_s;
                    pop_s = 1'b1;
                end else begin
                    fault_d = 1'b1;
                    pc_d    = pc_inc_s;
                end
                fin_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_HALT: begin
                // Absorbing until reset; pc frozen, no pulses.
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADV;
            pc_q      <= {PC_W{1'b0}};
            stk_pop_q <= 1'b0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            stk_pop_q <= stk_pop_d;
            fin_q     <= fin_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    // Return-address stack: entries plus occupancy count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_q <= {SPW{1'b0}};
            for (int i = 0; i < RET_DEPTH; i++) begin
                ret_q[i] <= {PC_W{1'b0}};
            end
        end else if (push_s) begin
            ret_q[wr_idx_s] <= pc_inc_s;
            sp_q            <= sp_q + SPW'(1);
        end else if (pop_s) begin
            sp_q <= sp_q - SPW'(1);
        end else begin
            sp_q <= sp_q;
        end
    end

    assign ctl.pc      = pc_q;
    assign ctl.stk_pop = stk_pop_q;
    assign ctl.fin_sig = fin_q;
    assign ctl.busy    = busy_q;
    assign ctl.halted  = halted_q;
    assign ctl.fault   = fault_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: scoreboard bench for pc_seq (INST_CAP=20, DATA_LEN=8, RET_DEPTH=4).
// The stimulus task pushes the hand-computed pc/fault/latency/pop count of
// every instruction; a monitor pops and compares on each fin_sig pulse.
module tb_pc_seq;

    logic clk;
    logic rstn;

    pc_seq_if #(.DATA_LEN(8), .PC_W(6)) u_if ();

    pc_seq #(.INST_CAP(20), .DATA_LEN(8), .RET_DEPTH(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ctl  (u_if.slave)
    );

    typedef struct {
        int pc;
        int fault;
        int lat;
        int pops;
    } exp_t;

    exp_t sb[$];
    int   n_pass    = 0;
    int   n_total   = 0;
    int   cyc       = 0;
    int   issue_cyc = 0;
    int   pop_cnt   = 0;
    logic fin_prev  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: counts pop strobes and scores every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (u_if.stk_pop) pop_cnt++;
        if (u_if.fin_sig) begin
            if (sb.size() == 0) begin
                chk("unexpected_fin", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pc", int'(u_if.pc), e.pc);
                chk("fault", int'(u_if.fault), e.fault);
                chk("latency", cyc - issue_cyc, e.lat);
                chk("pop_pulses", pop_cnt, e.pops);
                chk("fin_single", int'(fin_prev), 0);
            end
            pop_cnt = 0;
        end
        fin_prev = u_if.fin_sig;
    end

    // Issue one instruction; z0 is z_flag during POP, z1 at the BR edge.
    task automatic issue(input logic [3:0] b, input logic z0, input logic z1,
                         input logic s, input int data, input int epc, input int efault);
        exp_t e;
        int   k;
        logic br;
        br = (b == 4'd3) || (b == 4'd4) || (b == 4'd5) || (b == 4'd6);
        e.pc    = epc;
        e.fault = efault;
        e.lat   = br ? 3 : 2;
        e.pops  = br ? 1 : 0;
        @(negedge clk);
        u_if.en           = 1'b1;
        u_if.control_bus  = b;
        u_if.z_flag       = z0;
        u_if.s_flag       = s;
        u_if.stk_data_out = 8'(data);
        sb.push_back(e);
        issue_cyc = cyc;
        @(negedge clk);
        u_if.en     = 1'b0;
        u_if.z_flag = z1;
        k = 0;
        while (!u_if.fin_sig && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10) begin
            chk("fin_timeout", 0, 1);
            sb.delete();
        end
    endtask

    // Reset with en held high, check reset values, release.
    task automatic do_reset();
        @(negedge clk);
        u_if.en          = 1'b1;
        u_if.control_bus = 4'd0;
        rstn             = 1'b0;
        #1;
        chk("rst_pc", int'(u_if.pc), 0);
        chk("rst_stk_pop", int'(u_if.stk_pop), 0);
        chk("rst_fin", int'(u_if.fin_sig), 0);
        chk("rst_busy", int'(u_if.busy), 0);
        chk("rst_halted", int'(u_if.halted), 0);
        chk("rst_fault", int'(u_if.fault), 0);
        @(negedge clk);
        u_if.en = 1'b0;
        rstn    = 1'b1;
        sb.delete();
        pop_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn              = 1'b0;
        u_if.en           = 1'b1;
        u_if.control_bus  = 4'd0;
        u_if.z_flag       = 1'b0;
        u_if.s_flag       = 1'b0;
        u_if.stk_data_out = 8'd0;
        repeat (2) @(negedge clk);
        do_reset();

        // Advance, saturation at INST_CAP-1, conditional branches.
        issue(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1, 0);
        issue(4'b0001, 1'b0, 1'b0, 1'b0, 0, 2, 0);
        issue(4'b0010, 1'b0, 1'b0, 1'b0, 0, 3, 0);
        issue(4'b0011, 1'b0, 1'b0, 1'b0, 19, 19, 0);
        issue(4'b1000, 1'b0, 1'b0, 1'b0, 0, 19, 0);
        issue(4'b1110, 1'b0, 1'b0, 1'b0, 0, 19, 0);
        issue(4'b0000, 1'b0, 1'b0, 1'b0, 0, 19, 0);
        issue(4'b0011, 1'b0, 1'b0, 1'b0, 5, 5, 0);
        issue(4'b0100, 1'b0, 1'b0, 1'b0, 7, 6, 0);
        issue(4'b0100, 1'b1, 1'b1, 1'b0, 7, 7, 0);
        issue(4'b0101, 1'b0, 1'b0, 1'b1, 12, 12, 0);
        issue(4'b0101, 1'b0, 1'b0, 1'b0, 3, 13, 0);
        issue(4'b0100, 1'b1, 1'b0, 1'b0, 2, 14, 0);
        issue(4'b0100, 1'b0, 1'b1, 1'b0, 2, 2, 0);
        // CALL / RET / RET on empty stack.
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 10, 10, 0);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 0, 3, 0);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 0, 4, 1);

        // Return-stack overflow and unwind.
        do_reset();
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 10, 10, 0);
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 12, 12, 0);
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 14, 14, 0);
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 16, 16, 0);
        issue(4'b0110, 1'b0, 1'b0, 1'b0, 18, 17, 1);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 0, 15, 1);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 0, 13, 1);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 0, 11, 1);
        issue(4'b0111, 1'b0, 1'b0, 1'b0, 0, 1, 1);

        // Out-of-range target, then EXIT and halted behaviour.
        do_reset();
        issue(4'b0100, 1'b0, 1'b0, 1'b0, 25, 1, 0);
        issue(4'b0011, 1'b0, 1'b0, 1'b0, 25, 2, 1);
        @(negedge clk);
        u_if.en          = 1'b1;
        u_if.control_bus = 4'b1111;
        @(negedge clk);
        u_if.en = 1'b0;
        chk("halted", int'(u_if.halted), 1);
        chk("halt_busy", int'(u_if.busy), 0);
        pop_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            u_if.en          = 1'b1;
            u_if.control_bus = (i == 0) ? 4'b0000 : ((i == 1) ? 4'b0011 : 4'b0111);
            repeat (2) @(negedge clk);
            u_if.en = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("halt_pc", int'(u_if.pc), 2);
        chk("halt_pops", pop_cnt, 0);
        chk("halt_still", int'(u_if.halted), 1);
        chk("halt_fault", int'(u_if.fault), 1);

        // Asynchronous reset in the middle of a POP.
        do_reset();
        issue(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1, 0);
        @(negedge clk);
        u_if.en           = 1'b1;
        u_if.control_bus  = 4'b0011;
        u_if.stk_data_out = 8'd9;
        @(negedge clk);
        u_if.en = 1'b0;
        chk("midpop_strobe", int'(u_if.stk_pop), 1);
        chk("midpop_busy", int'(u_if.busy), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_pc", int'(u_if.pc), 0);
        chk("abort_stk_pop", int'(u_if.stk_pop), 0);
        chk("abort_busy", int'(u_if.busy), 0);
        chk("abort_fin", int'(u_if.fin_sig), 0);
        @(negedge clk);
        rstn    = 1'b1;
        pop_cnt = 0;
        repeat (4) @(negedge clk);
        chk("post_abort_pc", int'(u_if.pc), 0);
        chk("post_abort_pops", pop_cnt, 0);
        issue(4'b0000, 1'b0, 1'b0, 1'b0, 0, 1, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
